// File: rtl/arb_pkg.sv
// Shared types for the per-client request queue that feeds the ffs_arbiter.
package arb_pkg;

  localparam int CLIENTS_MAX = 16;
  localparam int ID_W        = 4;

  typedef logic [ID_W-1:0] client_id_t;

  // Output-buffer record at the default 32-bit payload width.
  typedef struct packed {
    client_id_t  client;
    logic [31:0] data;
  } out_entry_t;

  // Index of the set bit in a one-hot vector (all-zero input yields 0).
  function automatic client_id_t onehot_to_id(input logic [CLIENTS_MAX-1:0] oh);
    client_id_t id;
    id = '0;
    for (int i = 0; i < CLIENTS_MAX; i++) begin
      if (oh[i]) id = id | client_id_t'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and registered-memory head; DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Guard against over/underflow so an illegal request can never corrupt the pointers.
  assign do_push = push && (cnt != FULL_CNT);
  assign do_pop  = pop && (cnt != '0);
  assign head    = mem[rd_ptr];

  // NOTE: the storage array carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/arb_client_queue.sv
// Per-client request queues feeding an external ffs_arbiter, plus a 2-entry output buffer.
// Define ARB_CLIENT_QUEUE_CHECK_EN to flag and drop illegal grants on the sticky err output.
module arb_client_queue
  import arb_pkg::*;
#(
  parameter int CLIENTS = 16,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CLIENTS-1:0]        in_vld,
  output logic [CLIENTS-1:0]        in_rdy,
  input  logic [CLIENTS*DATA_W-1:0] in_data,
  output logic [CLIENTS-1:0]        req,
  input  logic [CLIENTS-1:0]        gnt,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [DATA_W-1:0]         out_data,
  output logic [3:0]                out_client,
  output logic                      err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    client_id_t        client;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [CW-1:0]      cnt  [CLIENTS];
  logic [DATA_W-1:0]  head [CLIENTS];
  logic [CLIENTS-1:0] nonempty;
  logic [CLIENTS-1:0] gnt_ok;
  logic [CLIENTS-1:0] pop;
  logic [1:0]         out_cnt;
  logic               any_gnt;
  logic               req_en;
  logic               out_push;
  logic               out_pop;
  entry_t             out_wr;
  entry_t             out_head;

  assign any_gnt = |gnt;
  // A grant already in flight must always find room in the output buffer.
  assign req_en  = (3'(out_cnt) + 3'(any_gnt)) <= 3'd1;

  for (genvar i = 0; i < CLIENTS; i++) begin : g_client
    assign nonempty[i] = (cnt[i] != '0);
    assign in_rdy[i]   = rst_n && (cnt[i] != FULL_CNT);
    assign req[i]      = rst_n && req_en && (cnt[i] > CW'(gnt[i]));

    sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (DEPTH)
    ) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (in_vld[i] && in_rdy[i]),
      .push_data (in_data[i*DATA_W +: DATA_W]),
      .pop       (pop[i]),
      .head      (head[i]),
      .cnt       (cnt[i])
    );
  end

`ifdef ARB_CLIENT_QUEUE_CHECK_EN
  logic gnt_bad;

  assign gnt_bad = any_gnt &&
                   (((gnt & (gnt - CLIENTS'(1))) != '0) ||
                    ((gnt & ~nonempty) != '0) ||
                    (out_cnt == 2'd2));
  assign gnt_ok  = gnt_bad ? '0 : gnt;

  always_ff @(posedge clk) begin
    if (!rst_n)       err <= 1'b0;
    else if (gnt_bad) err <= 1'b1;
  end
`else
  assign gnt_ok = gnt;
  assign err    = 1'b0;
`endif

  assign pop      = gnt_ok & nonempty;
  assign out_push = |pop;
  assign out_pop  = out_vld && out_rdy;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    out_wr        = '0;
    out_wr.client = onehot_to_id(CLIENTS_MAX'(pop));
    for (int i = 0; i < CLIENTS; i++) begin
      if (pop[i]) out_wr.data = out_wr.data | head[i];
    end
  end

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (2)
  ) u_out_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (out_push),
    .push_data (out_wr),
    .pop       (out_pop),
    .head      (out_head),
    .cnt       (out_cnt)
  );

  assign out_vld    = rst_n && (out_cnt != '0);
  assign out_data   = out_head.data;
  assign out_client = out_head.client;

endmodule
